// File: rtl/serial_addsub_n.sv
// serial_addsub_n -- bit-serial adder/subtractor built around one full-adder cell.
//
// The two WIDTH-bit operands are captured in parallel and then consumed
// LSB-first, one bit per clock. The result, carry-out and signed overflow are
// published together on the edge that completes the last bit.
//
// Ports:
//   clk    system clock, rising-edge active
//   rst    asynchronous reset, active-low
//   start  begin an operation (sampled only while busy=0)
//   sub    0: a + b + cin, 1: a - b (cin ignored)
//   cin    carry-in for add mode
//   a, b   WIDTH-bit operands, captured on the accepting edge
//   busy   high while bits are being shifted through the adder
//   done   one-cycle pulse; sum/cout/ovf are valid from this cycle
//   sum    result register (modulo 2^WIDTH)
//   cout   final carry-out; in sub mode 1 means no borrow
//   ovf    two's-complement overflow of the operation
module serial_addsub_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             carry;

  // Full-adder cell operating on the current LSBs of the operand shifters.
  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  logic bit_s;
  logic carry_nx;

  always_comb begin
    bit_s    = fa_sum(opa[0], opb[0], carry);
    carry_nx = fa_carry(opa[0], opb[0], carry);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        // IDLE and DONE both accept a new operation; DONE only differs in
        // that done is high during it, which is what allows back-to-back ops.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= a;
            // Subtraction is a + ~b + 1: invert B and force carry-in to 1.
            opb   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end

        SHIFT: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= carry_nx;
          res   <= {bit_s, res[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            // This edge handles the MSB: carry holds the carry into the MSB,
            // carry_nx the carry out of it; their XOR is signed overflow.
            sum   <= {bit_s, res[WIDTH-1:1]};
            cout  <= carry_nx;
            ovf   <= carry ^ carry_nx;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_n.sv
`timescale 1ns/1ps
module tb_serial_addsub_n;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] a_drv = '0;
  logic [15:0] b_drv = '0;
  logic        st4 = 1'b0, st8 = 1'b0, st16 = 1'b0;

  logic        busy4, done4, cout4, ovf4;
  logic [3:0]  sum4;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_addsub_n #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(st4), .sub(sub), .cin(cin),
    .a(a_drv[3:0]), .b(b_drv[3:0]),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));

  serial_addsub_n #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .sub(sub), .cin(cin),
    .a(a_drv[7:0]), .b(b_drv[7:0]),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  serial_addsub_n #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(st16), .sub(sub), .cin(cin),
    .a(a_drv), .b(b_drv),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16));

  typedef struct {
    int          w;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  function automatic logic get_done(input int w);
    case (w)
      4:       return done4;
      16:      return done16;
      default: return done8;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      4:       return busy4;
      16:      return busy16;
      default: return busy8;
    endcase
  endfunction

  function automatic logic [15:0] get_sum(input int w);
    case (w)
      4:       return {12'h000, sum4};
      16:      return sum16;
      default: return {8'h00, sum8};
    endcase
  endfunction

  function automatic logic get_cout(input int w);
    case (w)
      4:       return cout4;
      16:      return cout16;
      default: return cout8;
    endcase
  endfunction

  function automatic logic get_ovf(input int w);
    case (w)
      4:       return ovf4;
      16:      return ovf16;
      default: return ovf8;
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      4:       st4 = v;
      16:      st16 = v;
      default: st8 = v;
    endcase
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called #1 after an accepting edge; returns the number of edges until done
  // is seen (0 if it never appears within the bound). Leaves time at #1 after
  // the edge that raised done.
  task automatic wait_done(input int w, output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (get_done(w)) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                        input logic s, input logic c, output int lat);
    @(negedge clk);
    a_drv = av; b_drv = bv; sub = s; cin = c;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    wait_done(w, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          ndone;
    int          first_lat;
    logic [15:0] mask, av, bv, bb, esum;
    logic [16:0] full;
    logic        s, c, ecout, eovf;

    vecs[0]  = '{8,  16'h005A, 16'h003C, 1'b0, 1'b0, 16'h0096, 1'b0, 1'b1};
    vecs[1]  = '{8,  16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[2]  = '{8,  16'h0010, 16'h0020, 1'b1, 1'b1, 16'h00F0, 1'b0, 1'b0};
    vecs[3]  = '{8,  16'h0080, 16'h0001, 1'b1, 1'b1, 16'h007F, 1'b1, 1'b1};
    vecs[4]  = '{8,  16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0};
    vecs[5]  = '{8,  16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{4,  16'h0009, 16'h0008, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b1};
    vecs[7]  = '{4,  16'h000F, 16'h000F, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0};
    vecs[8]  = '{4,  16'h0007, 16'h0008, 1'b1, 1'b0, 16'h000F, 1'b0, 1'b1};
    vecs[9]  = '{16, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[10] = '{16, 16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[11] = '{16, 16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0};

    // Reset held with start asserted: everything stays cleared.
    rst = 1'b0;
    st4 = 1'b1; st8 = 1'b1; st16 = 1'b1;
    a_drv = 16'h5A5A; b_drv = 16'h3C3C;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rst%0d busy", i), {15'h0, busy8}, 16'h0);
      chk($sformatf("rst%0d done", i), {15'h0, done8}, 16'h0);
      chk($sformatf("rst%0d sum", i), get_sum(8), 16'h0);
      chk($sformatf("rst%0d cout", i), {15'h0, cout8}, 16'h0);
      chk($sformatf("rst%0d ovf", i), {15'h0, ovf8}, 16'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    st4 = 1'b0; st8 = 1'b0; st16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("idle%0d busy", i), {15'h0, busy8}, 16'h0);
    end

    // Directed vector table.
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, lat);
      chk($sformatf("vec%0d latency", i), 16'(lat), 16'(vecs[i].w));
      chk($sformatf("vec%0d sum", i), get_sum(vecs[i].w), vecs[i].sum);
      chk($sformatf("vec%0d cout", i), {15'h0, get_cout(vecs[i].w)}, {15'h0, vecs[i].cout});
      chk($sformatf("vec%0d ovf", i), {15'h0, get_ovf(vecs[i].w)}, {15'h0, vecs[i].ovf});
      chk($sformatf("vec%0d busy_in_done", i), {15'h0, get_busy(vecs[i].w)}, 16'h0);
    end

    // start pulsed while busy is ignored.
    @(negedge clk);
    a_drv = 16'h005A; b_drv = 16'h003C; sub = 1'b0; cin = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    ndone = 0; first_lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin
        a_drv = 16'h00FF; b_drv = 16'h00FF; sub = 1'b1; st8 = 1'b1;
      end
      if (k == 4) st8 = 1'b0;
      if (done8) begin
        ndone++;
        if (first_lat == 0) first_lat = k;
      end
    end
    chk("ignore done_count", 16'(ndone), 16'd1);
    chk("ignore latency", 16'(first_lat), 16'd8);
    chk("ignore sum", get_sum(8), 16'h0096);
    chk("ignore busy_after", {15'h0, busy8}, 16'h0);

    // Back-to-back: start in the done cycle.
    run_op(8, 16'h0010, 16'h0020, 1'b1, 1'b1, lat);
    chk("b2b first latency", 16'(lat), 16'd8);
    chk("b2b first sum", get_sum(8), 16'h00F0);
    a_drv = 16'h0001; b_drv = 16'h0002; sub = 1'b0; cin = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    chk("b2b accepted busy", {15'h0, busy8}, 16'h1);
    chk("b2b sum held", get_sum(8), 16'h00F0);
    chk("b2b cout held", {15'h0, cout8}, 16'h0);
    wait_done(8, lat);
    chk("b2b second latency", 16'(lat), 16'd8);
    chk("b2b second sum", get_sum(8), 16'h0003);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    a_drv = 16'h007F; b_drv = 16'h0001; sub = 1'b0; cin = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst busy", {15'h0, busy8}, 16'h0);
    chk("midrst done", {15'h0, done8}, 16'h0);
    chk("midrst sum", get_sum(8), 16'h0);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    chk("midrst no_done", 16'(ndone), 16'd0);
    chk("midrst sum_stays", get_sum(8), 16'h0);
    run_op(8, 16'h0001, 16'h0001, 1'b0, 1'b0, lat);
    chk("postrst latency", 16'(lat), 16'd8);
    chk("postrst sum", get_sum(8), 16'h0002);

    // Random sweep against an arithmetic reference model.
    foreach (vecs[j]) begin end
    for (int wi = 0; wi < 3; wi++) begin
      int w;
      w = (wi == 0) ? 4 : (wi == 1) ? 8 : 16;
      mask = (w == 16) ? 16'hFFFF : 16'((17'h1 << w) - 17'h1);
      for (int i = 0; i < 1000; i++) begin
        av = 16'($urandom) & mask;
        bv = 16'($urandom) & mask;
        s  = 1'($urandom_range(0, 1));
        c  = 1'($urandom_range(0, 1));
        bb = s ? (~bv & mask) : bv;
        full = {1'b0, av} + {1'b0, bb} + {16'h0, (s ? 1'b1 : c)};
        esum  = full[15:0] & mask;
        ecout = full[w];
        eovf  = (av[w-1] == bb[w-1]) && (esum[w-1] != av[w-1]);
        run_op(w, av, bv, s, c, lat);
        chk($sformatf("rnd w%0d #%0d latency", w, i), 16'(lat), 16'(w));
        chk($sformatf("rnd w%0d #%0d sum a=%h b=%h sub=%0d cin=%0d", w, i, av, bv, s, c),
            get_sum(w), esum);
        chk($sformatf("rnd w%0d #%0d cout", w, i), {15'h0, get_cout(w)}, {15'h0, ecout});
        chk($sformatf("rnd w%0d #%0d ovf", w, i), {15'h0, get_ovf(w)}, {15'h0, eovf});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
